// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for a shared datapath resource with a one-cycle turnaround
// between owners. Optional grant timeout is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned SELW     = $clog2(NREQ),
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [SELW-1:0] sel,
    output logic            valid
);

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

    state_e          state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            valid_q, valid_d;

    logic [SELW-1:0] win_idx;
    logic            win_found;
    logic [NREQ-1:0] win_onehot;
    logic [SELW-1:0] ptr_after_owner;
    logic            owner_req;
    logic            leave;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

    logic [HoldW-1:0] hold_q, hold_d, hold_inc;
    logic             others_pending;
    logic             timeout;
`endif

    // Scan from ptr upward with wrap; first requester found wins.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            int unsigned j;
            j = (int'(ptr_q) + k) % NREQ;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = SELW'(j);
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    assign owner_req       = req[sel_q];
    assign ptr_after_owner = (sel_q == SELW'(NREQ - 1)) ? '0 : sel_q + SELW'(1);

`ifdef ARB_TIMEOUT_EN
    assign hold_inc       = (hold_q == HoldW'(MAX_HOLD)) ? hold_q : hold_q + HoldW'(1);
    assign others_pending = |(req & ~gnt_q);
    assign timeout        = (hold_inc == HoldW'(MAX_HOLD)) && others_pending;
    assign leave          = !owner_req || timeout;
`else
    assign leave          = !owner_req;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = '0;
        valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            StIdle, StRelease: begin
                if (win_found) begin
                    state_d = StGrant;
                    sel_d   = win_idx;
                    gnt_d   = win_onehot;
                    valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StGrant: begin
                if (leave) begin
                    state_d = StRelease;
                    ptr_d   = ptr_after_owner;
                end else begin
                    gnt_d   = gnt_q;
                    valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = hold_inc;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (NREQ=2); covers the timeout build when
// ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [0:0] sel;
    logic       valid;

    int total;
    int bad;

    mem_port_arbiter #(
        .NREQ    (2),
        .SELW    (1),
        .MAX_HOLD(8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] g, input logic s,
                              input logic v);
        check({tag, ".gnt"}, 8'(gnt), 8'(g));
        check({tag, ".sel"}, 8'(sel), 8'(s));
        check({tag, ".valid"}, 8'(valid), 8'(v));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 2'b11;

        // Reset holds outputs low even with requests present.
        step(); expect_out("rst0", 2'b00, 1'b0, 1'b0);
        step(); expect_out("rst1", 2'b00, 1'b0, 1'b0);

        // Single request from IDLE.
        rst = 1'b0; req = 2'b10;
        step(); expect_out("single_gnt", 2'b10, 1'b1, 1'b1);
        req = 2'b00;
        step(); expect_out("single_rel", 2'b00, 1'b1, 1'b0);
        step(); expect_out("single_idle", 2'b00, 1'b1, 1'b0);

        // Simultaneous requests after reset: index 0 wins.
        rst = 1'b1;
        step(); expect_out("rst2", 2'b00, 1'b0, 1'b0);
        rst = 1'b0; req = 2'b11;
        step(); expect_out("sim_gnt0", 2'b01, 1'b0, 1'b1);
        step(); expect_out("sim_hold0", 2'b01, 1'b0, 1'b1);
        req = 2'b10;
        step(); expect_out("sim_dead", 2'b00, 1'b0, 1'b0);
        step(); expect_out("sim_gnt1", 2'b10, 1'b1, 1'b1);
        req = 2'b00;
        step(); expect_out("wrap_rel", 2'b00, 1'b1, 1'b0);
        req = 2'b11;
        step(); expect_out("wrap_gnt0", 2'b01, 1'b0, 1'b1);

`ifdef ARB_TIMEOUT_EN
        // Both held: 8 grant cycles, one dead cycle, alternate.
        for (int i = 2; i <= 8; i++) begin
            step(); expect_out($sformatf("to0_c%0d", i), 2'b01, 1'b0, 1'b1);
        end
        step(); expect_out("to0_dead", 2'b00, 1'b0, 1'b0);
        step(); expect_out("to1_c1", 2'b10, 1'b1, 1'b1);
        for (int i = 2; i <= 8; i++) begin
            step(); expect_out($sformatf("to1_c%0d", i), 2'b10, 1'b1, 1'b1);
        end
        step(); expect_out("to1_dead", 2'b00, 1'b1, 1'b0);
        step(); expect_out("to0b_c1", 2'b01, 1'b0, 1'b1);
        // Alone, the owner keeps the grant past MAX_HOLD.
        req = 2'b01;
        for (int i = 2; i <= 13; i++) begin
            step(); expect_out($sformatf("alone_c%0d", i), 2'b01, 1'b0, 1'b1);
        end
        req = 2'b10;
        step(); expect_out("alone_rel", 2'b00, 1'b0, 1'b0);
        step(); expect_out("alone_next", 2'b10, 1'b1, 1'b1);
`else
        // No preemption while the owner keeps requesting.
        for (int i = 0; i < 20; i++) begin
            step(); expect_out($sformatf("np_c%0d", i), 2'b01, 1'b0, 1'b1);
        end
        req = 2'b10;
        step(); expect_out("np_rel", 2'b00, 1'b0, 1'b0);
        step(); expect_out("np_next", 2'b10, 1'b1, 1'b1);
`endif

        // Reset during requester 1's grant.
        rst = 1'b1;
        step(); expect_out("midrst", 2'b00, 1'b0, 1'b0);
        rst = 1'b0; req = 2'b11;
        step(); expect_out("midrst_regnt", 2'b01, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one MIPS datapath resource (e.g. the single memory port behind a `mux2_1`-style selector) between `NREQ` requesters. It converts level requests into a one-hot grant and drives the resource's select input. It inserts one turnaround cycle between owners so the selected data path settles before the next owner drives it.

## Interface
- `NREQ`, 2, number of requesters; must be at least 2.
- `SELW`, `$clog2(NREQ)`, width of `sel`.
- `MAX_HOLD`, 8, maximum consecutive grant cycles per owner; used only with `ARB_TIMEOUT_EN`; must be at least 1.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  level request; bit i is held high for the whole transaction of requester i.
- `gnt`  out  NREQ  one-hot grant; all zero when no owner.
- `sel`  out  SELW  index of current/last owner; drives the shared mux select.
- `valid`  out  1  high exactly when `gnt` is non-zero.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: one owner.
  - RELEASE: one-cycle turnaround, no owner.
- Round-robin pointer `ptr` (SELW bits) holds the highest-priority index. Winner = first i with `req[i]=1`, scanning `ptr, ptr+1, … NREQ-1, 0, … ptr-1`.
- IDLE: if `req != 0`, go to GRANT with owner = winner; else stay.
- GRANT: stay while `req[owner]=1`; go to RELEASE when `req[owner]=0`. Requests from other requesters never preempt, except through the timeout (see Configuration).
- On leaving GRANT: `ptr <= (owner+1) mod NREQ`. Wrap is explicit; with NREQ=3 and owner=2, `ptr` becomes 0.
- RELEASE: if `req != 0`, go to GRANT with a new winner computed from the updated `ptr`; else go to IDLE.
- Outputs are registered:
  - In GRANT: `gnt = 1<<owner`, `sel = owner`, `valid = 1`.
  - In IDLE and RELEASE: `gnt = 0`, `valid = 0`, and `sel` holds its last value. This prevents a select glitch on the mux.
- Reset values: state IDLE, `ptr=0`, `gnt=0`, `sel=0`, `valid=0`, hold counter 0.
- Reset asserted mid-grant: all outputs return to reset values at the next edge. Requests are re-arbitrated from `ptr=0` after `rst` deasserts.
- Requesters must not assume ownership before seeing `gnt[i]=1`. Dropping `req[i]` while not granted is legal and ignored.

## Timing
- Grant latency from IDLE: `req` sampled high at edge N gives `gnt`/`valid` high after edge N (visible in cycle N+1).
- Release: `req[owner]` sampled low at edge M clears `gnt` after edge M. The next owner's `gnt` rises after edge M+1, so there is exactly one dead cycle.
- Minimum grant length is 1 cycle. Back-to-back ownership by the same requester also passes through RELEASE.
- Simultaneous requests in IDLE: the lowest index at or after `ptr` wins. Others wait with no starvation: each waits at most NREQ-1 other grants.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A hold counter increments each GRANT cycle and clears on entering GRANT.
  - When the counter reaches `MAX_HOLD` and any other `req` bit is high, go to RELEASE, advancing `ptr` as normal. The preempted requester keeps `req` high and re-competes.
  - If no other request is pending, the counter saturates at `MAX_HOLD` and the grant continues.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built and `MAX_HOLD` is ignored.
  - A grant lasts until the owner drops `req`.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `req=2'b11` -> `gnt=0`, `sel=0`, `valid=0` throughout.
- Single request: `req=2'b10` from IDLE -> `gnt=2'b10`, `sel=1`, `valid=1` one cycle later. Drop `req` -> `gnt=0` next cycle, with `sel` still 1.
- Simultaneous: `req=2'b11` after reset -> requester 0 wins. Drop `req[0]` -> one dead cycle, then `gnt=2'b10`. Next contest with `req=2'b11` -> requester 0 wins again, since `ptr` wrapped to 0.
- Non-preemption (macro off): requester 0 holds for 20 cycles with `req[1]=1` -> `gnt=2'b01` for all 20 cycles, then RELEASE, then `gnt=2'b10`.
- Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD=8`): both requesters held high -> grants alternate 8 cycles on and 1 dead cycle. With only requester 0 high, the grant persists beyond 8 cycles.
- Mid-grant reset: assert `rst` during requester 1's grant -> `gnt=0` next edge. After release with `req=2'b11` -> requester 0 granted.
